// File: rtl/lcd_char_responder.sv
// HD44780-style character LCD responder: decodes the 8-bit bus, keeps display RAM,
// address counter and busy timing, and exposes display contents on a side read port.
module lcd_char_responder #(
  parameter int BUSY_CYCLES  = 3700,
  parameter int CLEAR_CYCLES = 152000
) (
  input  logic       CLK,
  input  logic       btnr,
  input  logic [7:0] lcd_db_in,
  input  logic       lcd_rs,
  input  logic       lcd_rw,
  input  logic       lcd_e,
  output logic [7:0] lcd_db_out,
  output logic       lcd_db_oe,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_char,
  output logic       busy,
  output logic       disp_on,
  output logic       overrun
);

  localparam int MAX_CYCLES = (CLEAR_CYCLES > BUSY_CYCLES) ? CLEAR_CYCLES : BUSY_CYCLES;
  localparam int CNT_W = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] BUSY_LOAD  = CNT_W'(BUSY_CYCLES - 1);
  localparam logic [CNT_W-1:0] CLEAR_LOAD = CNT_W'(CLEAR_CYCLES - 1);

  typedef enum logic {ST_FILL, ST_IDLE} fill_state_t;

  fill_state_t state_reg, state_next;
  logic [6:0]  fill_addr_reg, fill_addr_next;
  logic [6:0]  ac_reg, ac_next;
  logic        id_reg, id_next;
  logic        disp_on_reg, disp_on_next;
  // {DL, N, F, cursor, blink, S}: accepted and held, but nothing downstream uses them
  logic [5:0]  cfg_unused_reg, cfg_unused_next;
  logic        overrun_reg, overrun_next;
  logic        busy_reg, busy_next;
  logic [CNT_W-1:0] busy_cnt_reg, busy_cnt_next;

  logic [10:0] meta_reg, sync_reg;
  logic        e_d_reg;
  logic [7:0]  lcd_db_out_reg, rd_char_reg;
  logic        lcd_db_oe_reg;

  logic [7:0]  ram [0:127];
  logic        ram_we;
  logic [6:0]  ram_waddr;
  logic [7:0]  ram_wdata;

  logic       e_s, rs_s, rw_s, exec;
  logic [7:0] db_s;

  assign e_s  = sync_reg[10];
  assign rs_s = sync_reg[9];
  assign rw_s = sync_reg[8];
  assign db_s = sync_reg[7:0];
  assign exec = e_d_reg & ~e_s;

  function automatic logic [6:0] step_addr(input logic [6:0] a, input logic inc);
    logic [6:0] r;
    if (inc) begin
      if (a == 7'h27)                    r = 7'h40;
      else if (a == 7'h67 || a == 7'h7F) r = 7'h00;
      else                               r = a + 7'd1;
    end else begin
      if (a == 7'h40)      r = 7'h27;
      else if (a == 7'h00) r = 7'h67;
      else                 r = a - 7'd1;
    end
    return r;
  endfunction

  always_comb begin
    state_next      = state_reg;
    fill_addr_next  = fill_addr_reg;
    ac_next         = ac_reg;
    id_next         = id_reg;
    disp_on_next    = disp_on_reg;
    cfg_unused_next = cfg_unused_reg;
    overrun_next    = overrun_reg;
    busy_next       = busy_reg;
    busy_cnt_next   = busy_cnt_reg;
    ram_we          = 1'b0;
    ram_waddr       = ac_reg;
    ram_wdata       = db_s;

    if (busy_reg) begin
      if (busy_cnt_reg == '0) busy_next = 1'b0;
      else                    busy_cnt_next = busy_cnt_reg - CNT_W'(1);
    end

    if (state_reg == ST_FILL) begin
      ram_we         = 1'b1;
      ram_waddr      = fill_addr_reg;
      ram_wdata      = 8'h20;
      fill_addr_next = fill_addr_reg + 7'd1;
      if (fill_addr_reg == 7'h7F) state_next = ST_IDLE;
    end

    // A fill only runs while busy, so bus writes can never collide with it
    if (exec) begin
      unique case ({rs_s, rw_s})
        2'b01: ;
        2'b11: begin
          if (!busy_reg) begin
            ac_next       = step_addr(ac_reg, id_reg);
            busy_next     = 1'b1;
            busy_cnt_next = BUSY_LOAD;
          end
        end
        2'b10: begin
          if (busy_reg) begin
            overrun_next = 1'b1;
          end else begin
            ram_we        = 1'b1;
            ac_next       = step_addr(ac_reg, id_reg);
            busy_next     = 1'b1;
            busy_cnt_next = BUSY_LOAD;
          end
        end
        default: begin
          if (busy_reg) begin
            overrun_next = 1'b1;
          end else begin
            busy_next     = 1'b1;
            busy_cnt_next = BUSY_LOAD;
            casez (db_s)
              8'b1???????: ac_next = db_s[6:0];
              8'b01??????: ;
              8'b001?????: cfg_unused_next[5:3] = db_s[4:2];
              8'b0001????: if (!db_s[3]) ac_next = step_addr(ac_reg, db_s[2]);
              8'b00001???: begin
                disp_on_next         = db_s[2];
                cfg_unused_next[2:1] = db_s[1:0];
              end
              8'b000001??: begin
                id_next            = db_s[1];
                cfg_unused_next[0] = db_s[0];
              end
              8'b0000001?: begin
                ac_next       = 7'h00;
                busy_cnt_next = CLEAR_LOAD;
              end
              8'b00000001: begin
                ac_next        = 7'h00;
                id_next        = 1'b1;
                state_next     = ST_FILL;
                fill_addr_next = 7'h00;
                busy_cnt_next  = CLEAR_LOAD;
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge btnr) begin
    if (btnr) begin
      meta_reg       <= '0;
      sync_reg       <= '0;
      e_d_reg        <= 1'b0;
      state_reg      <= ST_FILL;
      fill_addr_reg  <= 7'h00;
      ac_reg         <= 7'h00;
      id_reg         <= 1'b1;
      disp_on_reg    <= 1'b0;
      cfg_unused_reg <= '0;
      overrun_reg    <= 1'b0;
      busy_reg       <= 1'b1;
      busy_cnt_reg   <= CLEAR_LOAD;
      lcd_db_out_reg <= 8'h00;
      lcd_db_oe_reg  <= 1'b0;
      rd_char_reg    <= 8'h00;
    end else begin
      meta_reg       <= {lcd_e, lcd_rs, lcd_rw, lcd_db_in};
      sync_reg       <= meta_reg;
      e_d_reg        <= e_s;
      state_reg      <= state_next;
      fill_addr_reg  <= fill_addr_next;
      ac_reg         <= ac_next;
      id_reg         <= id_next;
      disp_on_reg    <= disp_on_next;
      cfg_unused_reg <= cfg_unused_next;
      overrun_reg    <= overrun_next;
      busy_reg       <= busy_next;
      busy_cnt_reg   <= busy_cnt_next;
      lcd_db_oe_reg  <= e_s & rw_s;
      if (e_s & rw_s)
        lcd_db_out_reg <= rs_s ? ram[ac_reg] : {busy_reg, ac_reg};
      rd_char_reg    <= (state_reg == ST_FILL) ? 8'h20 : ram[rd_addr];
    end
  end

  always_ff @(posedge CLK) begin
    if (ram_we) ram[ram_waddr] <= ram_wdata;
  end

  assign lcd_db_out = lcd_db_out_reg;
  assign lcd_db_oe  = lcd_db_oe_reg;
  assign rd_char    = rd_char_reg;
  assign busy       = busy_reg;
  assign disp_on    = disp_on_reg;
  assign overrun    = overrun_reg;

endmodule

// File: tb/tb_lcd_char_responder.sv
// Directed bench for lcd_char_responder: drives the LCD bus like the display driver
// and checks status/data reads, RAM contents via the side port and busy timing.
module tb_lcd_char_responder;

  localparam int BUSY_N  = 20;
  localparam int CLEAR_N = 200;

  logic       CLK = 1'b0;
  logic       btnr = 1'b1;
  logic [7:0] lcd_db_in = 8'h00;
  logic       lcd_rs = 1'b0;
  logic       lcd_rw = 1'b0;
  logic       lcd_e = 1'b0;
  logic [6:0] rd_addr = 7'h00;
  logic [7:0] lcd_db_out, rd_char;
  logic       lcd_db_oe, busy, disp_on, overrun;

  int n_cmp = 0;
  int n_err = 0;
  int run_len = 0;
  int last_pulse = 0;

  lcd_char_responder #(.BUSY_CYCLES(BUSY_N), .CLEAR_CYCLES(CLEAR_N)) dut (
    .CLK(CLK), .btnr(btnr), .lcd_db_in(lcd_db_in), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw),
    .lcd_e(lcd_e), .lcd_db_out(lcd_db_out), .lcd_db_oe(lcd_db_oe), .rd_addr(rd_addr),
    .rd_char(rd_char), .busy(busy), .disp_on(disp_on), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  // Length of the most recently completed busy pulse, in clock cycles
  always @(negedge CLK) begin
    if (busy) run_len = run_len + 1;
    else if (run_len != 0) begin
      last_pulse = run_len;
      run_len = 0;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs == exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_busy(input logic level, input int limit, input string tag);
    int k;
    k = 0;
    while (busy !== level && k < limit) begin
      tick(1);
      k++;
    end
    check(tag, 8'(busy), 8'(level));
  endtask

  task automatic bus_write(input logic rs, input logic [7:0] d, input bit wait_idle);
    $display("write rs=%0d db=%02h", rs, d);
    lcd_rs = rs; lcd_rw = 1'b0; lcd_db_in = d;
    tick(1);
    lcd_e = 1'b1;
    tick(6);
    lcd_e = 1'b0;
    tick(1);
    wait_busy(1'b1, 10, "busy_rise");
    if (wait_idle) begin
      wait_busy(1'b0, CLEAR_N + 20, "busy_fall");
      tick(2);
    end
  endtask

  task automatic bus_read(input logic rs, input logic [7:0] exp, input string tag);
    lcd_rs = rs; lcd_rw = 1'b1;
    tick(1);
    lcd_e = 1'b1;
    tick(5);
    $display("read  rs=%0d data=%02h oe=%0d", rs, lcd_db_out, lcd_db_oe);
    check({tag, "_oe"}, 8'(lcd_db_oe), 8'd1);
    check(tag, lcd_db_out, exp);
    lcd_e = 1'b0;
    tick(5);
    check({tag, "_oe_low"}, 8'(lcd_db_oe), 8'd0);
    check({tag, "_hold"}, lcd_db_out, exp);
    lcd_rw = 1'b0;
  endtask

  task automatic check_ram(input logic [6:0] a, input logic [7:0] exp, input string tag);
    rd_addr = a;
    tick(2);
    check(tag, rd_char, exp);
  endtask

  initial begin
    tick(3);
    check("rst_busy", 8'(busy), 8'd1);
    check("rst_oe", 8'(lcd_db_oe), 8'd0);
    check("rst_dbout", lcd_db_out, 8'h00);
    check("rst_rdchar", rd_char, 8'h00);
    check("rst_disp", 8'(disp_on), 8'd0);
    check("rst_overrun", 8'(overrun), 8'd0);

    btnr = 1'b0;
    tick(CLEAR_N + 10);
    check("autoclr_busy", 8'(busy), 8'd0);
    check("autoclr_disp", 8'(disp_on), 8'd0);
    check("autoclr_overrun", 8'(overrun), 8'd0);
    for (int a = 0; a < 128; a++) begin
      rd_addr = a[6:0];
      tick(1);
      check($sformatf("init_ram_%02h", a), rd_char, 8'h20);
    end
    bus_read(1'b0, 8'h00, "status_init");

    bus_write(1'b0, 8'h38, 1);
    bus_write(1'b0, 8'h0C, 1);
    bus_write(1'b0, 8'h06, 1);
    bus_write(1'b0, 8'h80, 1);
    bus_write(1'b1, 8'h31, 1);
    bus_write(1'b1, 8'h30, 1);
    bus_write(1'b1, 8'h32, 1);
    check("disp_on", 8'(disp_on), 8'd1);
    check_ram(7'h00, 8'h31, "ram_00");
    check_ram(7'h01, 8'h30, "ram_01");
    check_ram(7'h02, 8'h32, "ram_02");
    bus_read(1'b0, 8'h03, "status_03");

    bus_write(1'b0, 8'hA7, 1);
    bus_write(1'b1, 8'h41, 1);
    bus_write(1'b1, 8'h42, 1);
    check_ram(7'h27, 8'h41, "ram_27");
    check_ram(7'h40, 8'h42, "ram_40");
    bus_read(1'b0, 8'h41, "status_41");
    bus_write(1'b0, 8'h04, 1);
    bus_write(1'b0, 8'h80, 1);
    bus_write(1'b1, 8'h43, 1);
    check_ram(7'h00, 8'h43, "ram_00_dec");
    bus_read(1'b0, 8'h67, "status_dec_wrap");

    bus_write(1'b0, 8'h14, 1);
    bus_read(1'b0, 8'h00, "shift_right_wrap");
    bus_write(1'b0, 8'h10, 1);
    bus_read(1'b0, 8'h67, "shift_left_wrap");
    bus_write(1'b0, 8'h18, 1);
    bus_read(1'b0, 8'h67, "shift_display_nop");
    bus_write(1'b0, 8'h06, 1);
    bus_write(1'b0, 8'hFF, 1);
    bus_read(1'b0, 8'h7F, "set_ac_7f");
    bus_write(1'b0, 8'h14, 1);
    bus_read(1'b0, 8'h00, "shift_7f_wrap");

    bus_write(1'b0, 8'hA7, 1);
    bus_read(1'b1, 8'h41, "data_read_27");
    wait_busy(1'b0, BUSY_N + 20, "data_read_idle");
    bus_read(1'b0, 8'h40, "status_after_read");

    bus_write(1'b1, 8'h55, 0);
    tick(2);
    bus_write(1'b0, 8'h80, 0);
    wait_busy(1'b0, BUSY_N + 20, "overrun_idle");
    tick(2);
    check_int("busy_pulse_len", last_pulse, BUSY_N);
    check("overrun_set", 8'(overrun), 8'd1);
    bus_read(1'b0, 8'h41, "status_discarded");
    check_ram(7'h40, 8'h55, "ram_40_55");

    bus_write(1'b0, 8'h01, 0);
    bus_read(1'b0, 8'h80, "status_clear_busy");
    wait_busy(1'b0, CLEAR_N + 20, "clear_idle");
    tick(2);
    check_int("clear_pulse_len", last_pulse, CLEAR_N);
    bus_read(1'b0, 8'h00, "status_after_clear");
    check_ram(7'h40, 8'h20, "ram_40_cleared");
    check_ram(7'h27, 8'h20, "ram_27_cleared");

    bus_write(1'b0, 8'hE0, 1);
    bus_write(1'b1, 8'h5A, 1);
    check_ram(7'h60, 8'h5A, "ram_60");
    bus_read(1'b0, 8'h61, "status_61");
    bus_write(1'b0, 8'h01, 0);
    tick(49);
    btnr = 1'b1;
    tick(2);
    check("midrst_busy", 8'(busy), 8'd1);
    check("midrst_disp", 8'(disp_on), 8'd0);
    check("midrst_overrun", 8'(overrun), 8'd0);
    check("midrst_oe", 8'(lcd_db_oe), 8'd0);
    check("midrst_dbout", lcd_db_out, 8'h00);
    check("midrst_rdchar", rd_char, 8'h00);
    btnr = 1'b0;
    tick(1);
    wait_busy(1'b0, CLEAR_N + 20, "reclear_idle");
    tick(2);
    for (int a = 0; a < 128; a++) begin
      rd_addr = a[6:0];
      tick(1);
      check($sformatf("reclr_ram_%02h", a), rd_char, 8'h20);
    end
    bus_read(1'b0, 8'h00, "status_after_reclear");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_char_responder.md
Name: lcd_char_responder

Overview:
- Synthesizable responder for the HD44780-style 8-bit character-LCD bus (DB[7:0], RS, RW, E) that our PmodCLP display driver already drives.
- Decodes instructions and data writes, maintains display RAM, an address counter and a busy flag, and answers busy-flag and data reads.
- Serves as the in-fabric display model for checking the driver's sequences, with a side read port for display content.

Parameters:
- BUSY_CYCLES, 3700, CLK cycles busy after any non-clear/home instruction or data access (37 us at 100 MHz).
- CLEAR_CYCLES, 152000, CLK cycles busy after clear or home (1.52 ms); must be at least 128.

Ports:
- CLK  in  1  system clock, 100 MHz.
- btnr  in  1  asynchronous active-high reset.
- lcd_db_in  in  8  bus data from the driver.
- lcd_rs  in  1  register select: 0 = instruction/status, 1 = data.
- lcd_rw  in  1  1 = read, 0 = write.
- lcd_e  in  1  enable strobe, asynchronous to CLK.
- lcd_db_out  out  8  read data.
- lcd_db_oe  out  1  read data valid/drive enable.
- rd_addr  in  7  side-port display RAM address.
- rd_char  out  8  side-port data, registered, 1-cycle latency.
- busy  out  1  busy flag.
- disp_on  out  1  display-on bit (D).
- overrun  out  1  sticky: a write arrived while busy.

Behaviour:
- Reset (btnr=1, async) sets:
  - ac=0, I/D=1, S=0, disp_on=0, cursor/blink=0, overrun=0.
  - lcd_db_oe=0, lcd_db_out=0, rd_char=0.
  - busy=1 while the auto-clear below runs.
- Reset release starts an automatic clear: fill 0x20 over 128 cycles, then busy for the remainder of CLEAR_CYCLES.
- Display RAM is 128x8, indexed by the 7-bit address. Valid display addresses are 0x00-0x27 and 0x40-0x67.
- lcd_e, lcd_rs, lcd_rw and lcd_db_in go through 2-flop synchronizers.
  - A transaction executes on the cycle after the synced E falls (es_d=1, es=0).
  - RS, RW and DB are taken from the synced values at that falling edge.
  - The driver holds them stable for at least 3 CLK before E falls.
- Read drive: while synced E=1 and synced RW=1, lcd_db_oe=1. Otherwise lcd_db_oe=0 and lcd_db_out holds its last value.
  - RS=0: lcd_db_out = {busy, ac}.
  - RS=1: lcd_db_out = ram[ac].
- Address step (inc when I/D=1, dec when I/D=0):
  - inc wraps 0x27->0x40, 0x67->0x00, 0x7F->0x00; otherwise +1.
  - dec wraps 0x40->0x27, 0x00->0x67; otherwise -1.
- Instruction decode (RS=0, RW=0) uses the highest set bit:
  - 0x01 clear: fill 0x20 (one address/cycle, 128 cycles), ac=0, I/D=1; busy=CLEAR_CYCLES.
  - 0x02-0x03 home: ac=0, RAM untouched; busy=CLEAR_CYCLES.
  - 0x04-0x07 entry mode: I/D=DB1, S=DB0 (S stored only, no display shift).
  - 0x08-0x0F display control: disp_on=DB2, cursor=DB1, blink=DB0.
  - 0x10-0x1F shift: if DB3=0, step ac (right when DB2=1, left otherwise) with the wrap rules; DB3=1 changes nothing.
  - 0x20-0x3F function set: DL/N/F stored only.
  - 0x40-0x7F CGRAM address: accepted, no effect (no CGRAM).
  - 0x80-0xFF: ac=DB[6:0] as given, including invalid addresses.
  - Every instruction except clear and home: busy=BUSY_CYCLES.
- Data write (RS=1, RW=0): ram[ac]<=DB, ac steps; busy=BUSY_CYCLES.
- Data read (RS=1, RW=1): ac steps at E fall; busy=BUSY_CYCLES.
- Status read (RS=0, RW=1): no state change, allowed any time.
- Busy handling:
  - busy=1 from the execute cycle until the down-counter reaches 0.
  - Counter loads N-1, so busy is high for exactly N cycles.
- Writes while busy:
  - Instruction or data writes arriving while busy=1 are discarded and set overrun=1. overrun clears only on reset.
  - Data reads while busy return ram[ac] but do not step ac.
- Side port: rd_char <= ram[rd_addr] every cycle. It has lower priority than a clear fill, and reads 0x20 during a fill.
- Reset mid-clear or mid-busy aborts and restarts the automatic clear.

Test Plan:
- Reset, wait CLEAR_CYCLES+10 -> busy=0, rd_char=0x20 for all 128 addresses, disp_on=0, overrun=0.
- Write 0x38, 0x0C, 0x06, 0x80, then data 0x31 0x30 0x32, waiting for busy=0 between writes -> disp_on=1; ram[0..2]=0x31,0x30,0x32; status read returns 0x03.
- Write 0xA7, then data 0x41, 0x42 -> ram[0x27]=0x41, ram[0x40]=0x42, status=0x41. Write 0x04, then 0x80, then data 0x43 -> ram[0x00]=0x43, status=0x67.
- Write data 0x55, then write 0x80 two cycles after busy rises -> second write discarded, overrun=1, busy pulse exactly BUSY_CYCLES long.
- Status read immediately after 0x01 -> lcd_db_out=0x80, lcd_db_oe=1 only while E high; after CLEAR_CYCLES -> 0x00.
- Assert btnr during a 0x01 fill at cycle 50 -> outputs return to reset values, auto-clear restarts, and all RAM reads 0x20 afterwards.
